// File: rtl/column_run_coalescer.sv
// Collapses runs of identical column indices into (column, repeat) records so the
// SpMV engine issues one x-vector load per run instead of one per non-zero.
module column_run_coalescer #(
    parameter int unsigned COL_W   = 32,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned MAX_REP = 15,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_in_valid,
    input  logic [COL_W-1:0] i_in_col,
    output logic             o_in_ready,
    input  logic             i_flush,
    output logic             o_out_valid,
    output logic [COL_W-1:0] o_out_col,
    output logic [CNT_W-1:0] o_out_count,
    input  logic             i_out_ready,
    output logic             o_idle,
    output logic [31:0]      o_runs_out,
    output logic [31:0]      o_cols_in
);

    localparam int unsigned      TMO_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MAX_REP_C = CNT_W'(MAX_REP);
    localparam logic [TMO_W-1:0] TMO_C     = TMO_W'(TIMEOUT);
    localparam logic             TMO_EN    = (TIMEOUT != 0);

    typedef enum logic {StEmpty, StAccum} state_e;

    state_e             r_state;
    logic [COL_W-1:0]   r_acc_col;
    logic [CNT_W-1:0]   r_acc_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_out_valid;
    logic [COL_W-1:0]   r_out_col;
    logic [CNT_W-1:0]   r_out_count;
    logic [31:0]        r_runs_out;
    logic [31:0]        r_cols_in;

    logic w_acc_valid;
    logic w_out_free;
    logic w_accept;
    logic w_extend;
    logic w_tmo_hit;
    logic w_emit_in;
    logic w_emit_flush;
    logic w_emit_tmo;
    logic w_emit;

    assign w_acc_valid  = (r_state == StAccum);
    assign w_out_free   = !r_out_valid || i_out_ready;
    assign o_in_ready   = !i_flush && (!w_acc_valid || w_out_free);
    assign w_accept     = i_in_valid && o_in_ready;
    assign w_extend     = w_acc_valid && (i_in_col == r_acc_col) && (r_acc_cnt < MAX_REP_C);
    assign w_tmo_hit    = TMO_EN && (r_tmo == TMO_C);

    // Emit causes: accepted input closing the run, flush, or idle timeout.
    // Flush blocks acceptance and timeout defers to both, so at most one fires.
    assign w_emit_in    = w_accept && w_acc_valid && !w_extend;
    assign w_emit_flush = i_flush && w_acc_valid && w_out_free;
    assign w_emit_tmo   = w_acc_valid && !i_flush && !w_accept && w_tmo_hit && w_out_free;
    assign w_emit       = w_emit_in || w_emit_flush || w_emit_tmo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StEmpty;
            r_acc_col   <= '0;
            r_acc_cnt   <= '0;
            r_tmo       <= '0;
            r_out_valid <= 1'b0;
            r_out_col   <= '0;
            r_out_count <= '0;
            r_runs_out  <= '0;
            r_cols_in   <= '0;
        end else begin
            // A new record may overwrite one being consumed in the same cycle.
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_col   <= r_acc_col;
                r_out_count <= r_acc_cnt;
                r_runs_out  <= r_runs_out + 32'd1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                r_cols_in <= r_cols_in + 32'd1;
                r_tmo     <= '0;
                r_state   <= StAccum;
                if (w_extend) begin
                    r_acc_cnt <= r_acc_cnt + 1'b1;
                end else begin
                    r_acc_col <= i_in_col;
                    r_acc_cnt <= '0;
                end
            end else if (w_emit) begin
                r_state <= StEmpty;
                r_tmo   <= '0;
            end else if (w_acc_valid && TMO_EN && !w_tmo_hit) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_col   = r_out_col;
    assign o_out_count = r_out_count;
    assign o_idle      = !w_acc_valid && !r_out_valid;
    assign o_runs_out  = r_runs_out;
    assign o_cols_in   = r_cols_in;

endmodule

// File: tb/tb_column_run_coalescer.sv
// Bench for column_run_coalescer: run-length reference model compared every cycle,
// directed scenarios with literal expectations, and a long randomized stream.
module tb_column_run_coalescer;

    localparam int unsigned COL_W   = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned MAX_REP = 15;
    localparam int unsigned TMO     = 8;

    logic             clk;
    logic             reset;
    logic             i_in_valid;
    logic [COL_W-1:0] i_in_col;
    logic             i_flush;
    logic             i_out_ready;

    logic             o_in_ready;
    logic             o_out_valid;
    logic [COL_W-1:0] o_out_col;
    logic [CNT_W-1:0] o_out_count;
    logic             o_idle;
    logic [31:0]      o_runs_out;
    logic [31:0]      o_cols_in;

    logic             d0_in_ready;
    logic             d0_out_valid;
    logic [COL_W-1:0] d0_out_col;
    logic [CNT_W-1:0] d0_out_count;
    logic             d0_idle;
    logic [31:0]      d0_runs_out;
    logic [31:0]      d0_cols_in;

    column_run_coalescer #(
        .COL_W(COL_W), .CNT_W(CNT_W), .MAX_REP(MAX_REP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .i_in_valid(i_in_valid), .i_in_col(i_in_col), .o_in_ready(o_in_ready),
        .i_flush(i_flush),
        .o_out_valid(o_out_valid), .o_out_col(o_out_col), .o_out_count(o_out_count),
        .i_out_ready(i_out_ready), .o_idle(o_idle),
        .o_runs_out(o_runs_out), .o_cols_in(o_cols_in)
    );

    // Timeout-disabled instance, only examined in the timeout scenario.
    column_run_coalescer #(
        .COL_W(COL_W), .CNT_W(CNT_W), .MAX_REP(MAX_REP), .TIMEOUT(0)
    ) dut0 (
        .clk(clk), .reset(reset),
        .i_in_valid(i_in_valid), .i_in_col(i_in_col), .o_in_ready(d0_in_ready),
        .i_flush(i_flush),
        .o_out_valid(d0_out_valid), .o_out_col(d0_out_col), .o_out_count(d0_out_count),
        .i_out_ready(i_out_ready), .o_idle(d0_idle),
        .o_runs_out(d0_runs_out), .o_cols_in(d0_cols_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a pending run (column, length) and one held record (column, length).
    bit          m_pend, m_hold;
    logic [31:0] m_col, m_hcol;
    int          m_len, m_hlen, m_idle;
    logic [31:0] m_runs, m_cols;

    always @(posedge clk) begin : model
        bit          free, rdy, acc, emit;
        logic [31:0] e_col;
        int          e_len;
        if (reset) begin
            m_pend = 0; m_hold = 0; m_len = 0; m_hlen = 0; m_idle = 0;
            m_runs = 0; m_cols = 0;
        end else begin
            free = !m_hold || i_out_ready;
            rdy  = !i_flush && (!m_pend || free);
            acc  = i_in_valid && rdy;
            emit = 0;
            e_col = '0;
            e_len = 0;
            if (acc) begin
                m_cols = m_cols + 1;
                if (m_pend && i_in_col == m_col && m_len <= int'(MAX_REP)) begin
                    m_len++;
                end else begin
                    if (m_pend) begin
                        emit = 1; e_col = m_col; e_len = m_len;
                    end
                    m_pend = 1; m_col = i_in_col; m_len = 1;
                end
                m_idle = 0;
            end else if (m_pend && free && (i_flush || (TMO != 0 && m_idle >= int'(TMO)))) begin
                emit = 1; e_col = m_col; e_len = m_len;
                m_pend = 0; m_idle = 0;
            end else if (m_pend) begin
                m_idle++;
            end
            if (m_hold && i_out_ready) m_hold = 0;
            if (emit) begin
                m_hold = 1; m_hcol = e_col; m_hlen = e_len;
                m_runs = m_runs + 1;
            end
        end
    end

    // Handshake logs: accepted columns, emitted records, and records expanded back to columns.
    logic [31:0] q_acc[$];
    logic [31:0] q_exp[$];
    logic [31:0] rec_col[$];
    int          rec_cnt[$];

    always @(negedge clk) begin : compare
        chk("in_ready", o_in_ready, !i_flush && (!m_pend || !m_hold || i_out_ready));
        chk("out_valid", o_out_valid, m_hold);
        if (m_hold) begin
            chk("out_col", o_out_col, m_hcol);
            chk("out_count", o_out_count, m_hlen - 1);
        end
        chk("idle", o_idle, !m_pend && !m_hold);
        chk("runs_out", o_runs_out, m_runs);
        chk("cols_in", o_cols_in, m_cols);
        if (reset) begin
            q_acc.delete(); q_exp.delete(); rec_col.delete(); rec_cnt.delete();
        end else begin
            if (i_in_valid && o_in_ready) q_acc.push_back(i_in_col);
            if (o_out_valid && i_out_ready) begin
                rec_col.push_back(o_out_col);
                rec_cnt.push_back(int'(o_out_count));
                for (int k = 0; k <= int'(o_out_count); k++) q_exp.push_back(o_out_col);
            end
        end
    end

    function automatic logic [31:0] rcol(input int i);
        return (i < rec_col.size()) ? rec_col[i] : 32'hdead_beef;
    endfunction

    function automatic int rcnt(input int i);
        return (i < rec_cnt.size()) ? rec_cnt[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_in_valid = 0; i_flush = 0; reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic send(input logic [31:0] c);
        bit ok = 0;
        i_in_valid = 1; i_in_col = c;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = o_in_ready;
            tick();
        end
        i_in_valid = 0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic do_flush();
        bit ok = 0;
        i_flush = 1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = o_idle;
            tick();
        end
        i_flush = 0;
        if (!ok) chk("flush_timeout", 0, 1);
    endtask

    initial begin
        int          n_acc;
        int          sum_len;
        int          bad;
        logic [31:0] c;
        reset = 1; i_in_valid = 0; i_in_col = '0; i_flush = 0; i_out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk("reset_idle", o_idle, 1);
        chk("reset_out_valid", o_out_valid, 0);

        // T1: 5,5,5,7 -> (5,2),(7,0)
        do_reset();
        i_out_ready = 1;
        send(5); send(5); send(5); send(7);
        do_flush();
        chk("t1_nrec", rec_col.size(), 2);
        chk("t1_r0_col", rcol(0), 5);
        chk("t1_r0_cnt", rcnt(0), 2);
        chk("t1_r1_col", rcol(1), 7);
        chk("t1_r1_cnt", rcnt(1), 0);
        chk("t1_runs", o_runs_out, 2);
        chk("t1_cols", o_cols_in, 4);
        chk("t1_idle", o_idle, 1);

        // T2: 20 x column 9 -> (9,15) on the 17th input, (9,3) on flush
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(9);
            if (i == 16) begin
                chk("t2_sat_valid", o_out_valid, 1);
                chk("t2_sat_col", o_out_col, 9);
                chk("t2_sat_cnt", o_out_count, 15);
            end
        end
        do_flush();
        chk("t2_nrec", rec_col.size(), 2);
        chk("t2_r0_cnt", rcnt(0), 15);
        chk("t2_r1_col", rcol(1), 9);
        chk("t2_r1_cnt", rcnt(1), 3);

        // T3: backpressure holds (1,0) and refuses 3 until out_ready rises
        do_reset();
        i_out_ready = 0;
        send(1); send(2);
        i_in_valid = 1; i_in_col = 3;
        @(negedge clk);
        chk("t3_refused", o_in_ready, 0);
        chk("t3_hold_col", o_out_col, 1);
        chk("t3_hold_cnt", o_out_count, 0);
        tick();
        i_out_ready = 1;
        @(negedge clk);
        chk("t3_ready_back", o_in_ready, 1);
        tick();
        i_in_valid = 0;
        chk("t3_next_valid", o_out_valid, 1);
        chk("t3_next_col", o_out_col, 2);
        do_flush();
        chk("t3_nrec", rec_col.size(), 3);
        chk("t3_r0_col", rcol(0), 1);
        chk("t3_r1_col", rcol(1), 2);
        chk("t3_r2_col", rcol(2), 3);

        // T4: timeout emits 9 cycles after acceptance; disabled instance waits for flush
        do_reset();
        i_out_ready = 1;
        send(4);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (o_out_valid) bad++;
            tick();
        end
        chk("t4_early_emit", bad, 0);
        chk("t4_tmo_valid", o_out_valid, 1);
        chk("t4_tmo_col", o_out_col, 4);
        chk("t4_tmo_cnt", o_out_count, 0);
        chk("t4_nt_valid", d0_out_valid, 0);
        chk("t4_nt_idle", d0_idle, 0);
        i_flush = 1;
        tick();
        i_flush = 0;
        chk("t4_nt_flush_valid", d0_out_valid, 1);
        chk("t4_nt_flush_col", d0_out_col, 4);
        chk("t4_nt_flush_cnt", d0_out_count, 0);
        chk("t4_nt_runs", d0_runs_out, 1);

        // T5: reset mid-run discards the pending run
        do_reset();
        send(3); send(3);
        do_reset();
        chk("t5_out_valid", o_out_valid, 0);
        chk("t5_idle", o_idle, 1);
        chk("t5_runs", o_runs_out, 0);
        chk("t5_cols", o_cols_in, 0);
        send(3);
        do_flush();
        chk("t5_nrec", rec_col.size(), 1);
        chk("t5_r0_col", rcol(0), 3);
        chk("t5_r0_cnt", rcnt(0), 0);

        // T6: random columns 0..3 with random backpressure and occasional flush
        do_reset();
        n_acc = 0;
        for (int n = 0; n < 40000 && n_acc < 10000; n++) begin
            i_in_valid  = ($urandom_range(9) < 7);
            i_in_col    = $urandom_range(3);
            i_out_ready = ($urandom_range(9) < 6);
            i_flush     = ($urandom_range(99) < 2);
            @(negedge clk);
            if (i_in_valid && o_in_ready) n_acc++;
            tick();
        end
        chk("t6_inputs", n_acc, 10000);
        i_in_valid = 0; i_flush = 0; i_out_ready = 1;
        do_flush();
        chk("t6_stream_len", q_exp.size(), q_acc.size());
        bad = -1;
        for (int i = 0; i < q_acc.size() && i < q_exp.size(); i++) begin
            if (bad < 0 && q_exp[i] !== q_acc[i]) bad = i;
        end
        chk("t6_stream_first_diff", bad, -1);
        sum_len = 0;
        for (int i = 0; i < rec_cnt.size(); i++) sum_len += rec_cnt[i] + 1;
        chk("t6_conservation", sum_len, o_cols_in);
        c = o_runs_out;
        chk("t6_runs", rec_col.size(), c);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
